// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encoding, FSM states and
// the byte-count helper used when a request is accepted.
package lsu_pkg;

  // Access size, matching the memory's write-command encoding.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  // Number of bytes in an access minus one; this is the final byte index.
  function automatic logic [1:0] nbytes_m1(input size_t size);
    case (size)
      SZ_BYTE: nbytes_m1 = 2'd0;
      SZ_HALF: nbytes_m1 = 2'd1;
      SZ_WORD: nbytes_m1 = 2'd3;
      default: nbytes_m1 = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load result extension: picks the low 1/2/4 bytes of the assembled load
// buffer and sign- or zero-extends them to 32 bits. Purely combinational so
// it can be reused in the writeback stage.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] ld_buf,
  input  size_t       size,
  input  logic        uns,
  output logic [31:0] rdata
);

  logic ext_byte_s;
  logic ext_half_s;

  // Fill bit is the top bit of the loaded quantity unless zero-extending.
  always_comb begin
    ext_byte_s = uns ? 1'b0 : ld_buf[7];
    ext_half_s = uns ? 1'b0 : ld_buf[15];
  end

  // Select the loaded width and extend.
  always_comb begin
    case (size)
      SZ_BYTE: rdata = {{24{ext_byte_s}}, ld_buf[7:0]};
      SZ_HALF: rdata = {{16{ext_half_s}}, ld_buf[15:0]};
      SZ_WORD: rdata = ld_buf;
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one core request at a time and serialises it into
// little-endian byte transactions on a req/ack memory port, so memories with
// arbitrary wait states are supported. Load bytes are collected in a buffer
// and extended by load_extend when the last byte arrives.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word requests return
// resp_err without touching memory instead of being performed byte-by-byte.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  lsu_state_t        state_r;
  logic              we_r;
  size_t             size_r;
  logic              uns_r;
  logic [ADDR_W-1:0] base_r;
  logic [XLEN-1:0]   wdata_r;
  logic [1:0]        idx_r;
  logic [1:0]        last_r;
  logic [XLEN-1:0]   buf_r;

  logic              req_ready_r;
  logic              resp_valid_r;
  logic [XLEN-1:0]   resp_rdata_r;
  logic              resp_err_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        mem_wdata_r;

  logic              misalign_s;
  logic              req_bad_s;
  logic [1:0]        idx_inc_s;
  logic [XLEN-1:0]   buf_nxt_s;
  logic [XLEN-1:0]   ext_s;

`ifdef MISALIGN_TRAP_EN
  assign misalign_s = ((req_size == 2'b01) && (req_addr[0] != 1'b0)) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  // Requests that complete with an error and never reach memory.
  always_comb begin
    req_bad_s = (req_size == 2'b11) || misalign_s;
    idx_inc_s = idx_r + 2'd1;
  end

  // Load buffer including the byte being acknowledged this cycle, so the
  // final byte is visible to the extender on the same edge it is captured.
  always_comb begin
    buf_nxt_s = buf_r;
    if (mem_req_r && mem_ack && !we_r) begin
      buf_nxt_s[{idx_r, 3'b000} +: 8] = mem_rdata;
    end else begin
      buf_nxt_s = buf_r;
    end
  end

  load_extend u_load_extend (
    .ld_buf (buf_nxt_s),
    .size   (size_r),
    .uns    (uns_r),
    .rdata  (ext_s)
  );

  // Request / access / response FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      we_r         <= 1'b0;
      size_r       <= SZ_BYTE;
      uns_r        <= 1'b0;
      base_r       <= '0;
      wdata_r      <= '0;
      idx_r        <= 2'd0;
      last_r       <= 2'd0;
      buf_r        <= '0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= '0;
      resp_err_r   <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready_r) begin
            we_r        <= req_we;
            size_r      <= size_t'(req_size);
            uns_r       <= req_unsigned;
            base_r      <= req_addr;
            wdata_r     <= req_wdata;
            idx_r       <= 2'd0;
            buf_r       <= '0;
            req_ready_r <= 1'b0;
            if (req_bad_s) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= '0;
            end else begin
              state_r     <= ACCESS;
              last_r      <= nbytes_m1(size_t'(req_size));
              mem_req_r   <= 1'b1;
              mem_we_r    <= req_we;
              mem_addr_r  <= req_addr;
              mem_wdata_r <= req_wdata[7:0];
            end
          end
        end
        ACCESS: begin
          // Without an ack every mem_* register simply holds its value.
          if (mem_ack) begin
            buf_r <= buf_nxt_s;
            if (idx_r == last_r) begin
              state_r      <= RESP;
              mem_req_r    <= 1'b0;
              mem_we_r     <= 1'b0;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b0;
              resp_rdata_r <= we_r ? '0 : ext_s;
            end else begin
              idx_r       <= idx_inc_s;
              mem_addr_r  <= base_r + ADDR_W'(idx_inc_s);
              mem_wdata_r <= wdata_r[{idx_inc_s, 3'b000} +: 8];
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= '0;
            req_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= '0;
          mem_req_r    <= 1'b0;
          mem_we_r     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of requests with
// hand-computed results/latencies, a byte memory model with programmable
// ack delay, and hand-written sequences for reset and mid-access reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  int ack_delay = 0;
  int wait_cnt = 0;
  int stall_viol = 0;
  int req_cycles = 0;
  logic        stall_pend = 1'b0;
  logic [41:0] stall_snap = 42'd0;

  logic [31:0] log_addr[$];
  logic        log_we[$];
  logic [7:0]  log_data[$];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_n;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  load_store_unit #(.ADDR_W(32), .XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  // Read-only byte memory contents used by the load vectors.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_byte = 8'hAA;
      32'h0000_0001: mem_byte = 8'h81;
      32'h0000_0002: mem_byte = 8'h0F;
      32'h0000_0003: mem_byte = 8'hF0;
      32'h0000_0004: mem_byte = 8'h91;
      32'h0000_0005: mem_byte = 8'h22;
      32'h0000_0006: mem_byte = 8'h33;
      32'h0000_0007: mem_byte = 8'h44;
      32'h0000_001B: mem_byte = 8'h82;
      32'h0000_001C: mem_byte = 8'h2A;
      32'hFFFF_FFFE: mem_byte = 8'h5A;
      32'hFFFF_FFFF: mem_byte = 8'hC3;
      default:       mem_byte = 8'h00;
    endcase
  endfunction

  assign mem_rdata = mem_byte(mem_addr);
  assign mem_ack   = mem_req && (wait_cnt == ack_delay);

  // Memory-side monitor: ack timing, transaction log, stall stability.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt   <= 0;
      stall_pend <= 1'b0;
    end else begin
      if (stall_pend && ({mem_req, mem_we, mem_addr, mem_wdata} != stall_snap))
        stall_viol <= stall_viol + 1;
      stall_pend <= mem_req && !mem_ack;
      stall_snap <= {mem_req, mem_we, mem_addr, mem_wdata};
      if (mem_req) req_cycles <= req_cycles + 1;
      if (mem_req && mem_ack) begin
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_data.push_back(mem_wdata);
        wait_cnt <= 0;
      end else if (mem_req) begin
        wait_cnt <= wait_cnt + 1;
      end else begin
        wait_cnt <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", nm, act, exp);
    end
  endtask

  // Apply one table vector, measure latency, hold the response, check log.
  task automatic run_vec(input int id, input vec_t v);
    int lbase;
    int rbase;
    int lat;
    int n;
    bit found;
    logic [31:0] exp_a;
    logic [31:0] wd;
    lbase = log_addr.size();
    rbase = req_cycles;
    ack_delay    = v.dly;
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 32'h5555_5555;
    lat = 0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (resp_valid) begin
        found = 1'b1;
        lat = k + 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk($sformatf("v%0d_latency", id), lat, v.exp_lat);
    if (found) begin
      for (int h = 0; h < v.hold; h++) begin
        chk($sformatf("v%0d_hold_valid", id), {31'd0, resp_valid}, 32'd1);
        chk($sformatf("v%0d_hold_reqrdy", id), {31'd0, req_ready}, 32'd0);
        chk($sformatf("v%0d_hold_rdata", id), resp_rdata, v.exp_rdata);
        @(posedge clk); #1;
      end
      chk($sformatf("v%0d_rdata", id), resp_rdata, v.exp_rdata);
      chk($sformatf("v%0d_err", id), {31'd0, resp_err}, {31'd0, v.exp_err});
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk($sformatf("v%0d_valid_drop", id), {31'd0, resp_valid}, 32'd0);
      chk($sformatf("v%0d_req_ready", id), {31'd0, req_ready}, 32'd1);
    end
    n = log_addr.size() - lbase;
    chk($sformatf("v%0d_nbytes", id), n, v.exp_n);
    if (n == v.exp_n) begin
      for (int i = 0; i < n; i++) begin
        exp_a = v.addr + 32'(i);
        wd = v.wdata >> (8 * i);
        chk($sformatf("v%0d_addr%0d", id, i), log_addr[lbase + i], exp_a);
        chk($sformatf("v%0d_we%0d", id, i), {31'd0, log_we[lbase + i]}, {31'd0, v.we});
        if (v.we)
          chk($sformatf("v%0d_wbyte%0d", id, i), {24'd0, log_data[lbase + i]}, {24'd0, wd[7:0]});
      end
    end
    if (v.exp_n == 0)
      chk($sformatf("v%0d_no_memreq", id), req_cycles - rbase, 0);
  endtask

  initial begin
    int lbase;
    int rbase;
    // we, size, uns, addr, wdata, dly, hold, exp_rdata, exp_err, exp_lat, exp_n
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 0, 0, 32'hF00F81AA, 1'b0, 5, 4};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0, 0, 0, 32'hFFFFFF81, 1'b0, 2, 1};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0, 0, 0, 32'h00000081, 1'b0, 2, 1};
    vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_001B, 32'h0, 0, 0, 32'h00002A82, 1'b0, 3, 2};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 0, 0, 32'hFFFFF00F, 1'b0, 3, 2};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0, 0, 0, 32'h0000F00F, 1'b0, 3, 2};
    vecs[6]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0, 0, 0, 32'h00000000, 1'b1, 1, 0};
    vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0, 3, 2};
    vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0, 2, 4, 32'h44332291, 1'b0, 13, 4};
    vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0020, 32'h12345678, 1, 0, 32'h0, 1'b0, 3, 1};
`ifdef MISALIGN_TRAP_EN
    vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0, 0, 0, 32'h0, 1'b1, 1, 0};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 0, 0, 32'h0, 1'b1, 1, 0};
`else
    vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0, 0, 0, 32'hFFFF91F0, 1'b0, 3, 2};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 0, 0, 32'h81AAC35A, 1'b0, 5, 4};
`endif
    vecs[12] = '{1'b0, 2'b10, 1'b1, 32'h0000_0000, 32'h0, 0, 0, 32'hF00F81AA, 1'b0, 5, 4};
    vecs[13] = '{1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'hA1B2C3D4, 1, 0, 32'h0, 1'b0, 9, 4};

    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    resp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset in the middle of the second byte of a stalled word store.
    lbase = log_addr.size();
    ack_delay    = 3;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h0000_0040;
    req_wdata    = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_bytes_before_reset", log_addr.size() - lbase, 1);
    chk("mid_mem_req_before", {31'd0, mem_req}, 32'd1);
    chk("mid_addr_byte1", mem_addr, 32'h0000_0041);
    reset = 1'b1;
    #1;
    chk("mid_mem_req_async", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rbase = req_cycles;
    chk("mid_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_no_more_bytes", log_addr.size() - lbase, 1);
    chk("mid_no_mem_req", req_cycles - rbase, 0);
    chk("mid_mem_req_idle", {31'd0, mem_req}, 32'd0);

    // Unit must work normally after the abandoned request.
    run_vec(NV, vecs[1]);
    chk("stall_stability", stall_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
